// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Shared geometry and state encodings for the LLR frame
//                packer. Holds the default lane count, LLR width and beats
//                per frame, plus the fill and drain FSM state types.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

   localparam int LANES = 32;   // LLR lanes per decoder beat
   localparam int W     = 16;   // LLR width, two's complement
   localparam int BEATS = 16;   // beats per frame

   // Fill side: accept samples, zero-pad a short frame, or stall on a busy bank
   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      WAIT = 2'd2
   } fill_state_t;

   // Drain side: wait for a full bank, then stream it out beat by beat
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/llr_pingpong_ram.sv
`default_nettype none
// ============================================================================
//  Module      : llr_pingpong_ram
//  Description : Two frame banks of BEATS words x LANES lanes x W bits.
//                One lane-granular write port, one full-word read port with
//                a registered output (one cycle read latency).
//  Ports       : clk                  - clock
//                wr_en/wr_bank/wr_beat/wr_lane/wr_data - single-LLR write
//                rd_bank/rd_beat      - read address
//                rd_data              - registered full beat, lane k at
//                                       [k*W +: W]
//  Revision    : 1.0 - initial release
// ============================================================================
module llr_pingpong_ram #(
   parameter int LANES = ldpc_pkg::LANES,
   parameter int W     = ldpc_pkg::W,
   parameter int BEATS = ldpc_pkg::BEATS,
   parameter int LB    = $clog2(LANES),
   parameter int BB    = $clog2(BEATS)
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic               wr_bank,
   input  logic [BB-1:0]      wr_beat,
   input  logic [LB-1:0]      wr_lane,
   input  logic [W-1:0]       wr_data,
   input  logic               rd_bank,
   input  logic [BB-1:0]      rd_beat,
   output logic [LANES*W-1:0] rd_data
);

   // Each lane is its own narrow memory so a single LLR can be written
   // without a read-modify-write of the whole beat word.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [W-1:0] mem [2*BEATS];
      logic [W-1:0] q;

      always_ff @(posedge clk) begin
         if (wr_en && (wr_lane == LB'(k))) begin
            mem[{wr_bank, wr_beat}] <= wr_data;
         end
         q <= mem[{rd_bank, rd_beat}];
      end

      assign rd_data[k*W +: W] = q;
   end

endmodule
`default_nettype wire

// File: rtl/llr_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : llr_frame_packer
//  Description : Collects a serial LLR stream into LANES x BEATS frames in a
//                ping-pong buffer and replays each frame to the decoder as
//                BEATS wide beats. Short frames (early s_last) are padded with
//                zero (erasure) LLRs.
//  Ports       : clk, rst_n (sync, active low)
//                s_valid/s_ready/s_data/s_last - serial LLR input
//                cfg_z        - lifting size, latched with a frame's 1st sample
//                dec_ready    - decoder can take a whole frame
//                m_valid/m_data/m_z - beat output to decoder (zero when idle)
//                err_nolast   - sticky: frame filled without s_last
//  Revision    : 1.0 - initial release
// ============================================================================
module llr_frame_packer #(
   parameter int LANES = ldpc_pkg::LANES,
   parameter int W     = ldpc_pkg::W,
   parameter int BEATS = ldpc_pkg::BEATS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [W-1:0]       s_data,
   input  logic               s_last,
   input  logic [15:0]        cfg_z,
   input  logic               dec_ready,
   output logic               m_valid,
   output logic [LANES*W-1:0] m_data,
   output logic [15:0]        m_z,
   output logic               err_nolast
);
   import ldpc_pkg::*;

   localparam int            LB        = $clog2(LANES);
   localparam int            BB        = $clog2(BEATS);
   localparam logic [LB-1:0] LANE_LAST = LB'(LANES - 1);
   localparam logic [BB-1:0] BEAT_LAST = BB'(BEATS - 1);

   // Fill side
   fill_state_t   fill_state;
   logic          wr_bank;
   logic [LB-1:0] lane_cnt, lane_nxt;
   logic [BB-1:0] beat_cnt, beat_nxt;

   // Drain side
   drain_state_t  drain_state;
   logic          rd_bank;
   logic [BB-1:0] rd_beat, rd_beat_inc, rd_addr;

   // Shared bank bookkeeping
   logic [1:0]    full;
   logic [1:0]    set_bank, free_bank;
   logic [15:0]   bank_z [2];

   logic          accept, pad_wr, wr_en, at_last_slot, frame_done;
   logic          next_busy, wait_busy;
   logic [W-1:0]  wr_data;
   logic [LANES*W-1:0] rd_data;

   // s_ready is forced low while reset is asserted so nothing is offered
   // to the source before the FSMs are in a known state.
   assign s_ready      = rst_n && (fill_state == FILL) && !full[wr_bank];
   assign accept       = s_valid && s_ready;
   assign pad_wr       = (fill_state == PAD);
   assign wr_en        = accept || pad_wr;
   assign wr_data      = pad_wr ? '0 : s_data;
   assign at_last_slot = (lane_cnt == LANE_LAST) && (beat_cnt == BEAT_LAST);
   assign frame_done   = wr_en && at_last_slot;

   // A bank being released by the drain this cycle counts as free, so the
   // fill side can reuse it on the very next cycle.
   assign next_busy    = full[~wr_bank] && !free_bank[~wr_bank];
   assign wait_busy    = full[wr_bank]  && !free_bank[wr_bank];

   always_comb begin
      lane_nxt = lane_cnt + 1'b1;
      beat_nxt = beat_cnt;
      if (lane_cnt == LANE_LAST) begin
         lane_nxt = '0;
         beat_nxt = beat_cnt + 1'b1;
      end
   end

   always_comb begin
      set_bank  = '0;
      free_bank = '0;
      if (frame_done) begin
         set_bank[wr_bank] = 1'b1;
      end
      if ((drain_state == SEND) && (rd_beat == BEAT_LAST)) begin
         free_bank[rd_bank] = 1'b1;
      end
   end

   // ---------------------------------------------------------------- fill FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_state <= FILL;
         wr_bank    <= 1'b0;
         lane_cnt   <= '0;
         beat_cnt   <= '0;
         err_nolast <= 1'b0;
      end else begin
         case (fill_state)
            FILL: begin
               if (accept) begin
                  if (at_last_slot) begin
                     lane_cnt   <= '0;
                     beat_cnt   <= '0;
                     wr_bank    <= ~wr_bank;
                     fill_state <= next_busy ? WAIT : FILL;
                     if (!s_last) begin
                        err_nolast <= 1'b1;
                     end
                  end else begin
                     lane_cnt <= lane_nxt;
                     beat_cnt <= beat_nxt;
                     if (s_last) begin
                        fill_state <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               if (at_last_slot) begin
                  lane_cnt   <= '0;
                  beat_cnt   <= '0;
                  wr_bank    <= ~wr_bank;
                  fill_state <= next_busy ? WAIT : FILL;
               end else begin
                  lane_cnt <= lane_nxt;
                  beat_cnt <= beat_nxt;
               end
            end
            WAIT: begin
               if (!wait_busy) begin
                  fill_state <= FILL;
               end
            end
            default: fill_state <= FILL;
         endcase
      end
   end

   // Lifting size travels with the first sample of each frame.
   always_ff @(posedge clk) begin
      if (accept && (lane_cnt == '0) && (beat_cnt == '0)) begin
         bank_z[wr_bank] <= cfg_z;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         full <= (full & ~free_bank) | set_bank;
      end
   end

   // --------------------------------------------------------------- drain FSM
   // The RAM read is registered, so the address runs one beat ahead of the
   // beat currently on m_data: beat 0 is fetched while still in IDLE.
   assign rd_beat_inc = rd_beat + 1'b1;
   assign rd_addr     = (drain_state == SEND) ? rd_beat_inc : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drain_state <= IDLE;
         rd_bank     <= 1'b0;
         rd_beat     <= '0;
         m_valid     <= 1'b0;
         m_z         <= '0;
      end else begin
         case (drain_state)
            IDLE: begin
               if (full[rd_bank] && dec_ready) begin
                  drain_state <= SEND;
                  rd_beat     <= '0;
                  m_valid     <= 1'b1;
                  m_z         <= bank_z[rd_bank];
               end
            end
            SEND: begin
               if (rd_beat == BEAT_LAST) begin
                  drain_state <= IDLE;
                  rd_beat     <= '0;
                  rd_bank     <= ~rd_bank;
                  m_valid     <= 1'b0;
                  m_z         <= '0;
               end else begin
                  rd_beat <= rd_beat_inc;
               end
            end
            default: drain_state <= IDLE;
         endcase
      end
   end

   assign m_data = m_valid ? rd_data : '0;

   llr_pingpong_ram #(
      .LANES (LANES),
      .W     (W),
      .BEATS (BEATS),
      .LB    (LB),
      .BB    (BB)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_beat (beat_cnt),
      .wr_lane (lane_cnt),
      .wr_data (wr_data),
      .rd_bank (rd_bank),
      .rd_beat (rd_addr),
      .rd_data (rd_data)
   );

endmodule
`default_nettype wire

// File: doc/llr_frame_packer.md
LLR_FRAME_PACKER -- requirements
Module: llr_frame_packer

Interface
REQ-001 SHALL have parameter LANES, default 32, meaning LLR lanes per decoder beat.
REQ-002 SHALL have parameter W, default 16, meaning LLR width in bits, two's complement.
REQ-003 SHALL have parameter BEATS, default 16, meaning beats per frame; frame size = LANES*BEATS = 512 LLRs.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port s_valid, input, 1, serial LLR sample valid.
REQ-007 SHALL have port s_ready, output, 1, packer accepts a sample this cycle.
REQ-008 SHALL have port s_data, input, W, serial LLR sample.
REQ-009 SHALL have port s_last, input, 1, marks the last sample of a frame.
REQ-010 SHALL have port cfg_z, input, 16, lifting size, sampled with the first sample of each frame.
REQ-011 SHALL have port dec_ready, input, 1, downstream decoder idle and able to take a full frame.
REQ-012 SHALL have port m_valid, output, 1, drives decoder i_valid.
REQ-013 SHALL have port m_data, output, LANES*W, lane k at bits [k*W+W-1 : k*W], drives decoder data_in_k.
REQ-014 SHALL have port m_z, output, 16, drives decoder i_z.
REQ-015 SHALL have port err_nolast, output, 1, sticky: 512th sample arrived without s_last.

Function
REQ-016 SHALL hold two frame banks (ping-pong), each BEATS words of LANES*W bits, plus a latched z and a full flag per bank.
REQ-017 Fill side SHALL accept a sample when s_valid and s_ready are both high, write it to lane counter position of beat counter row, increment lane counter 0..LANES-1, and wrap it to 0 while incrementing the beat counter.
REQ-018 s_ready SHALL be high only in fill state FILL with the write bank not full.
REQ-019 On the 512th accepted sample the bank SHALL be marked full, counters SHALL clear, and the write bank SHALL toggle; if s_last is low on that sample, err_nolast SHALL set.
REQ-020 s_last on an earlier sample SHALL move the fill FSM to PAD, with s_ready low, writing 0 (erasure LLR) into one remaining slot per cycle until slot 511 is written, then mark the bank full and toggle as in REQ-019.
REQ-021 Fill FSM states SHALL be FILL, PAD, WAIT; WAIT is entered when the newly selected write bank is still full, and FILL resumes the cycle after that bank is freed.
REQ-022 Drain FSM states SHALL be IDLE and SEND; IDLE->SEND when the read bank is full and dec_ready is high.
REQ-023 In SEND, m_valid SHALL be high for exactly BEATS consecutive cycles presenting beats 0..BEATS-1 in order, with m_z constant at the bank's latched z; dec_ready is ignored once SEND has started.
REQ-024 After the last beat, the read bank SHALL be freed, the read bank SHALL toggle, and the FSM SHALL return to IDLE, giving at least one idle cycle between frames.
REQ-025 Latency: first m_valid SHALL appear 1 cycle after the cycle in which the bank-full flag is set, provided dec_ready is high.
REQ-026 A bank freed in the same cycle in which the fill side requests it SHALL become writable on the next cycle.
REQ-027 m_data and m_z SHALL be 0 whenever m_valid is low.
REQ-028 Both FSMs SHALL run concurrently, filling one bank while draining the other without loss.

Reset
REQ-029 rst_n low at a clock edge SHALL clear counters, full flags, bank selects, and err_nolast, and SHALL set the fill FSM to FILL and the drain FSM to IDLE; s_ready=0, m_valid=0, m_data=0, m_z=0 during reset.
REQ-030 Reset mid-frame or mid-SEND SHALL abandon partial data; bank contents need not be cleared.

Structure
REQ-031 LANES, W, BEATS and the FSM state encodings SHALL live in the shared package ldpc_pkg.
REQ-032 The two banks SHALL be one sub-module, llr_pingpong_ram (one write port, one read port, registered read).

Verification
REQ-033 Full frame of 512 samples 1..512, s_last on the last, z=7 with dec_ready=1 -> 16 m_valid beats; beat 0 lane 0 = 1, beat 15 lane 31 = 512; m_z=7; err_nolast=0.
REQ-034 s_last on the 40th sample -> PAD lasts 472 cycles; beat 1 lanes 8..31 and beats 2..15 all 0; s_ready low throughout PAD.
REQ-035 Two back-to-back frames with dec_ready low -> s_ready drops after frame 2 (WAIT); raising dec_ready drains frame 1 then frame 2 with an idle gap >=1 cycle; third frame then accepted.
REQ-036 512 samples without s_last -> err_nolast=1 and the frame is still emitted; err_nolast stays 1 until reset.
REQ-037 rst_n low for 1 cycle at SEND beat 5 -> m_valid=0 next cycle; a fresh frame afterwards is emitted correctly.
REQ-038 Random s_valid gaps (50%) -> output identical to the gap-free run of REQ-033.
